// File: rtl/control_unit.sv
// control_unit: HRM CPU instruction decoder with one cycle of registered latency.
// Opcode in, datapath strobes out. The only state is the output register.

package control_unit_pkg;

  localparam int unsigned OPC_W  = 4;
  localparam int unsigned MUXR_W = 2;
  localparam int unsigned ALU_W  = 3;

  // HRM opcode map
  typedef enum logic [OPC_W-1:0] {
    OP_INBOX     = 4'd0,
    OP_OUTBOX    = 4'd1,
    OP_COPYFROM  = 4'd2,
    OP_COPYTO    = 4'd3,
    OP_ADD       = 4'd4,
    OP_SUB       = 4'd5,
    OP_BUMPP     = 4'd6,
    OP_BUMPM     = 4'd7,
    OP_JUMP      = 4'd8,
    OP_JUMPZ     = 4'd9,
    OP_JUMPN     = 4'd10,
    OP_COPYFROMI = 4'd11,
    OP_COPYTOI   = 4'd12,
    OP_ADDI      = 4'd13,
    OP_SUBI      = 4'd14,
    OP_NOP       = 4'd15
  } opcode_e;

  // R-register source select
  localparam logic [MUXR_W-1:0] MUXR_INBOX = 2'b00;
  localparam logic [MUXR_W-1:0] MUXR_MEM   = 2'b01;
  localparam logic [MUXR_W-1:0] MUXR_ALU   = 2'b10;

  // ALU operations; 110/111 are never produced
  localparam logic [ALU_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB   = 3'b001;
  localparam logic [ALU_W-1:0] ALU_INC   = 3'b010;
  localparam logic [ALU_W-1:0] ALU_DEC   = 3'b011;
  localparam logic [ALU_W-1:0] ALU_TSTZ  = 3'b100;
  localparam logic [ALU_W-1:0] ALU_TSTN  = 3'b101;

  // Bundle of all datapath control strobes; all-zero is the NOP/reset state
  typedef struct packed {
    logic [MUXR_W-1:0] mux_r;
    logic              w_r;
    logic              mux_m;
    logic              w_m;
    logic [ALU_W-1:0]  alu_ctl;
    logic              branch;
    logic              ijump;
    logic              r_in;
    logic              w_o;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

module control_unit
  import control_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OPC_W-1:0]    instr,
  output logic [MUXR_W-1:0]   muxR,
  output logic                wR,
  output logic                muxM,
  output logic                wM,
  output logic [ALU_W-1:0]    aluCtl,
  output logic                branch,
  output logic                ijump,
  output logic                rIn,
  output logic                wO
);

  opcode_e opcode;
  ctrl_t   ctrl_d;
  ctrl_t   ctrl_q;

  assign opcode = opcode_e'(instr);

  // Combinational decode of the opcode into the next control word
  always_comb begin
    ctrl_d = CTRL_NOP;
    unique case (opcode)
      OP_INBOX: begin
        ctrl_d.mux_r = MUXR_INBOX;
        ctrl_d.w_r   = 1'b1;
        ctrl_d.r_in  = 1'b1;
      end
      OP_OUTBOX: begin
        ctrl_d.w_o = 1'b1;
      end
      OP_COPYFROM: begin
        ctrl_d.mux_r = MUXR_MEM;
        ctrl_d.w_r   = 1'b1;
      end
      OP_COPYTO: begin
        ctrl_d.w_m = 1'b1;
      end
      OP_ADD: begin
        ctrl_d.mux_r   = MUXR_ALU;
        ctrl_d.w_r     = 1'b1;
        ctrl_d.alu_ctl = ALU_ADD;
      end
      OP_SUB: begin
        ctrl_d.mux_r   = MUXR_ALU;
        ctrl_d.w_r     = 1'b1;
        ctrl_d.alu_ctl = ALU_SUB;
      end
      OP_BUMPP: begin
        ctrl_d.mux_r   = MUXR_ALU;
        ctrl_d.w_r     = 1'b1;
        ctrl_d.w_m     = 1'b1;
        ctrl_d.alu_ctl = ALU_INC;
      end
      OP_BUMPM: begin
        ctrl_d.mux_r   = MUXR_ALU;
        ctrl_d.w_r     = 1'b1;
        ctrl_d.w_m     = 1'b1;
        ctrl_d.alu_ctl = ALU_DEC;
      end
      OP_JUMP: begin
        ctrl_d.ijump = 1'b1;
      end
      OP_JUMPZ: begin
        ctrl_d.branch  = 1'b1;
        ctrl_d.alu_ctl = ALU_TSTZ;
      end
      OP_JUMPN: begin
        ctrl_d.branch  = 1'b1;
        ctrl_d.alu_ctl = ALU_TSTN;
      end
      OP_COPYFROMI: begin
        ctrl_d.mux_r = MUXR_MEM;
        ctrl_d.w_r   = 1'b1;
        ctrl_d.mux_m = 1'b1;
      end
      OP_COPYTOI: begin
        ctrl_d.w_m   = 1'b1;
        ctrl_d.mux_m = 1'b1;
      end
      OP_ADDI: begin
        ctrl_d.mux_r   = MUXR_ALU;
        ctrl_d.w_r     = 1'b1;
        ctrl_d.mux_m   = 1'b1;
        ctrl_d.alu_ctl = ALU_ADD;
      end
      OP_SUBI: begin
        ctrl_d.mux_r   = MUXR_ALU;
        ctrl_d.w_r     = 1'b1;
        ctrl_d.mux_m   = 1'b1;
        ctrl_d.alu_ctl = ALU_SUB;
      end
      OP_NOP: begin
        ctrl_d = CTRL_NOP;
      end
      default: begin
        ctrl_d = CTRL_NOP;
      end
    endcase
  end

  // Output register; reset clears every strobe immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= CTRL_NOP;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign muxR   = ctrl_q.mux_r;
  assign wR     = ctrl_q.w_r;
  assign muxM   = ctrl_q.mux_m;
  assign wM     = ctrl_q.w_m;
  assign aluCtl = ctrl_q.alu_ctl;
  assign branch = ctrl_q.branch;
  assign ijump  = ctrl_q.ijump;
  assign rIn    = ctrl_q.r_in;
  assign wO     = ctrl_q.w_o;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: opcode table sweep plus reset/latency sequences.
`timescale 1ns/1ps

module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [3:0] instr;
  logic [1:0] muxR;
  logic       wR;
  logic       muxM;
  logic       wM;
  logic [2:0] aluCtl;
  logic       branch;
  logic       ijump;
  logic       rIn;
  logic       wO;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  instr;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [16];

  control_unit dut (
    .clk    (clk),
    .rst    (rst),
    .instr  (instr),
    .muxR   (muxR),
    .wR     (wR),
    .muxM   (muxM),
    .wM     (wM),
    .aluCtl (aluCtl),
    .branch (branch),
    .ijump  (ijump),
    .rIn    (rIn),
    .wO     (wO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack outputs as {muxR,wR,muxM,wM,aluCtl,branch,ijump,rIn,wO}
  function automatic logic [11:0] mk(input logic [1:0] mr, input logic wr, input logic mm,
                                      input logic wm, input logic [2:0] alu, input logic br,
                                      input logic ij, input logic ri, input logic wo);
    return {mr, wr, mm, wm, alu, br, ij, ri, wo};
  endfunction

  function automatic logic [11:0] outs();
    return {muxR, wR, muxM, wM, aluCtl, branch, ijump, rIn, wO};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %03h expected %03h", name, act, exp);
    end
  endtask

  initial begin
    logic [11:0] e;
    vecs[0]  = '{4'd0,  mk(2'b00, 1, 0, 0, 3'b000, 0, 0, 1, 0)};
    vecs[1]  = '{4'd1,  mk(2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 1)};
    vecs[2]  = '{4'd2,  mk(2'b01, 1, 0, 0, 3'b000, 0, 0, 0, 0)};
    vecs[3]  = '{4'd3,  mk(2'b00, 0, 0, 1, 3'b000, 0, 0, 0, 0)};
    vecs[4]  = '{4'd4,  mk(2'b10, 1, 0, 0, 3'b000, 0, 0, 0, 0)};
    vecs[5]  = '{4'd5,  mk(2'b10, 1, 0, 0, 3'b001, 0, 0, 0, 0)};
    vecs[6]  = '{4'd6,  mk(2'b10, 1, 0, 1, 3'b010, 0, 0, 0, 0)};
    vecs[7]  = '{4'd7,  mk(2'b10, 1, 0, 1, 3'b011, 0, 0, 0, 0)};
    vecs[8]  = '{4'd8,  mk(2'b00, 0, 0, 0, 3'b000, 0, 1, 0, 0)};
    vecs[9]  = '{4'd9,  mk(2'b00, 0, 0, 0, 3'b100, 1, 0, 0, 0)};
    vecs[10] = '{4'd10, mk(2'b00, 0, 0, 0, 3'b101, 1, 0, 0, 0)};
    vecs[11] = '{4'd11, mk(2'b01, 1, 1, 0, 3'b000, 0, 0, 0, 0)};
    vecs[12] = '{4'd12, mk(2'b00, 0, 1, 1, 3'b000, 0, 0, 0, 0)};
    vecs[13] = '{4'd13, mk(2'b10, 1, 1, 0, 3'b000, 0, 0, 0, 0)};
    vecs[14] = '{4'd14, mk(2'b10, 1, 1, 0, 3'b001, 0, 0, 0, 0)};
    vecs[15] = '{4'd15, 12'h000};

    // Reset with BUMP+ presented and clock running
    rst   = 1'b1;
    instr = 4'd6;
    #2;
    check("reset_async", outs(), 12'h000);
    repeat (3) begin
      @(posedge clk); #1;
      check("reset_hold", outs(), 12'h000);
    end
    @(negedge clk) rst = 1'b0;
    #1 check("reset_release_no_edge", outs(), 12'h000);
    @(posedge clk); #1;
    check("reset_release_bump", outs(), vecs[6].exp);

    // Opcode sweep, one per clock
    for (int i = 0; i < 16; i++) begin
      @(negedge clk) instr = vecs[i].instr;
      @(posedge clk); #1;
      check($sformatf("sweep_op%0d", i), outs(), vecs[i].exp);
    end

    // Hold constant keeps outputs constant
    @(negedge clk) instr = 4'd9;
    repeat (3) begin
      @(posedge clk); #1;
      check("hold_jumpz", outs(), vecs[9].exp);
    end

    // Latency: OUTBOX then JUMP presented just after the edge
    @(negedge clk) instr = 4'd1;
    @(posedge clk); #1;
    check("lat_outbox", outs(), vecs[1].exp);
    instr = 4'd8;
    #3 check("lat_hold_before_edge", outs(), vecs[1].exp);
    @(posedge clk); #1;
    check("lat_jump", outs(), vecs[8].exp);

    // Mid-operation reset pulse between edges
    @(negedge clk) instr = 4'd12;
    @(posedge clk); #1;
    check("mid_copytoi", outs(), vecs[12].exp);
    #1 rst = 1'b1;
    #1 check("mid_rst_clear", outs(), 12'h000);
    #1 rst = 1'b0;
    #1 check("mid_rst_stays_clear", outs(), 12'h000);
    @(posedge clk); #1;
    check("mid_rst_reload", outs(), vecs[12].exp);

    // Reset held across a rising edge wins over the edge
    @(negedge clk) begin instr = 4'd7; rst = 1'b1; end
    @(posedge clk); #1;
    check("rst_over_edge", outs(), 12'h000);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("after_rst_bumpm", outs(), vecs[7].exp);

    // Random stream: model compare plus invariants
    for (int c = 0; c < 1000; c++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      @(negedge clk) instr = op;
      @(posedge clk); #1;
      e = vecs[op].exp;
      check($sformatf("rand_op%0d", op), outs(), e);
      checks++;
      if ((branch & ijump) || (rIn & wO) || (wO & (wR | wM)) ||
          (aluCtl == 3'b110) || (aluCtl == 3'b111) || (muxR == 2'b11)) begin
        errors++;
        $display("FAIL invariant: op=%0d outputs=%03h required no conflicting strobes", op, outs());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000ns");
    $fatal(1);
  end

endmodule
